// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 frame master: 16-bit {wr,addr,wdata} frames, MSB first
// All outputs are registered from next-state values, so nothing combinational reaches a pin.
module spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       wr,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       sclk,
  output logic       copi,
  output logic       ncs,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT_HI, SHIFT_LO, GAP} state_t;

  // Counter spans the GAP (2*CLK_DIV cycles), which needs 9 bits at CLK_DIV=255.
  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST  = 9'(2 * CLK_DIV - 1);

  state_t      state, state_n;
  logic [8:0]  cnt, cnt_n;
  logic [15:0] shreg, shreg_n;
  logic [3:0]  bitcnt, bitcnt_n;
  logic        sclk_n, copi_n, ncs_n, busy_n, done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 9'd0;
      shreg  <= 16'd0;
      bitcnt <= 4'd0;
      sclk   <= 1'b0;
      copi   <= 1'b0;
      ncs    <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shreg  <= shreg_n;
      bitcnt <= bitcnt_n;
      sclk   <= sclk_n;
      copi   <= copi_n;
      ncs    <= ncs_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 9'd1;
    shreg_n  = shreg;
    bitcnt_n = bitcnt;
    sclk_n   = sclk;
    copi_n   = copi;
    ncs_n    = ncs;
    busy_n   = busy;
    done_n   = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = 9'd0;
        if (start) begin
          shreg_n  = {wr, addr, wdata};
          bitcnt_n = 4'd15;
          state_n  = LEAD;
          ncs_n    = 1'b0;
          sclk_n   = 1'b0;
          copi_n   = wr;
          busy_n   = 1'b1;
        end
      end
      LEAD: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = 9'd0;
          state_n = SHIFT_HI;
          sclk_n  = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt == HALF_LAST) begin
          cnt_n   = 9'd0;
          state_n = SHIFT_LO;
          sclk_n  = 1'b0;
          // Data moves on the falling edge, half a period clear of both rising edges.
          if (bitcnt != 4'd0) begin
            shreg_n = shreg << 1;
            copi_n  = shreg[14];
          end
        end
      end
      SHIFT_LO: begin
        if (cnt == HALF_LAST) begin
          cnt_n = 9'd0;
          if (bitcnt != 4'd0) begin
            bitcnt_n = bitcnt - 4'd1;
            state_n  = SHIFT_HI;
            sclk_n   = 1'b1;
          end else begin
            state_n = GAP;
            ncs_n   = 1'b1;
            copi_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = 9'd0;
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 9'd0;
        sclk_n  = 1'b0;
        copi_n  = 1'b0;
        ncs_n   = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - randomized bench for spi_controller with a behavioural SPI peripheral
// Two instances (CLK_DIV=4 and 255) share one waveform monitor selected by sel.
module tb_spi_controller;

  localparam int DA = 4;
  localparam int DB = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       wr = 1'b0;
  logic [6:0] addr = 7'd0;
  logic [7:0] wdata = 8'd0;
  logic       sel = 1'b0;

  logic start_a, start_b;
  logic sclk_a, copi_a, ncs_a, busy_a, done_a;
  logic sclk_b, copi_b, ncs_b, busy_b, done_b;
  logic m_sclk, m_copi, m_ncs, m_busy, m_done;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign m_sclk  = sel ? sclk_b : sclk_a;
  assign m_copi  = sel ? copi_b : copi_a;
  assign m_ncs   = sel ? ncs_b  : ncs_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;

  spi_controller #(.CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .wr(wr), .addr(addr), .wdata(wdata),
    .sclk(sclk_a), .copi(copi_a), .ncs(ncs_a), .busy(busy_a), .done(done_a)
  );

  spi_controller #(.CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .wr(wr), .addr(addr), .wdata(wdata),
    .sclk(sclk_b), .copi(copi_b), .ncs(ncs_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  // Peripheral: samples copi on sclk rise, commits a write on ncs rise only for a full 16-bit frame.
  logic [7:0]  periph  [128] = '{default: 8'h00};
  logic [7:0]  exp_regs[128] = '{default: 8'h00};
  int cyc = 0, edges = 0, low_start = 0, last_tog = 0, hp_min = 0, hp_max = 0, viol = 0;
  int last_rise = -100000, last_chg = 0, high_start = 0;
  int fr_edges = 0, fr_low = 0, fr_min = 0, fr_max = 0, fr_viol = 0, frames = 0;
  int last_high = 0, dones = 0, stray = 0, acc_cnt = 0, acc_last = 0, acc_prev = 0;
  logic [15:0] shbits = 16'd0, fr_bits = 16'd0;
  logic p_sclk = 1'b0, p_copi = 1'b0, p_ncs = 1'b1, p_busy = 1'b0;

  initial forever begin
    int d;
    @(negedge clk);
    d = sel ? DB : DA;
    cyc++;
    if (p_ncs === 1'b1 && m_ncs === 1'b0) begin
      edges = 0; shbits = 16'd0; low_start = cyc; last_tog = cyc;
      hp_min = 1000000; hp_max = 0; viol = 0; last_rise = -100000;
      last_high = cyc - high_start;
    end
    if (m_ncs === 1'b0 && m_sclk !== p_sclk) begin
      if (cyc - last_tog < hp_min) hp_min = cyc - last_tog;
      if (cyc - last_tog > hp_max) hp_max = cyc - last_tog;
      last_tog = cyc;
      if (m_sclk === 1'b1) begin
        edges++;
        shbits = {shbits[14:0], m_copi};
        if (cyc - last_chg < d) viol++;
        last_rise = cyc;
      end
    end
    if (m_ncs === 1'b1 && m_sclk === 1'b1 && p_sclk === 1'b0) stray++;
    if (m_copi !== p_copi) begin
      if (cyc - last_rise < d) viol++;
      last_chg = cyc;
    end
    if (p_ncs === 1'b0 && m_ncs === 1'b1) begin
      if (cyc - last_tog < hp_min) hp_min = cyc - last_tog;
      if (cyc - last_tog > hp_max) hp_max = cyc - last_tog;
      fr_low = cyc - low_start; fr_edges = edges; fr_bits = shbits;
      fr_min = hp_min; fr_max = hp_max; fr_viol = viol; frames++;
      if (edges == 16 && shbits[15]) periph[shbits[14:8]] = shbits[7:0];
      high_start = cyc;
    end
    if (m_done === 1'b1) dones++;
    if (m_busy === 1'b1 && p_busy === 1'b0) begin
      acc_prev = acc_last; acc_last = cyc; acc_cnt++;
    end
    p_sclk = m_sclk; p_copi = m_copi; p_ncs = m_ncs; p_busy = m_busy;
  end

  function automatic int cur_div();
    return sel ? DB : DA;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (m_busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) check("timeout_idle", 1, 0);
  endtask

  task automatic check_frame(input logic [15:0] exp, input int d);
    check("frame_bits", int'(fr_bits), int'(exp));
    check("sclk_edges", fr_edges, 16);
    check("ncs_low_len", fr_low, 33 * d);
    check("half_min", fr_min, d);
    check("half_max", fr_max, d);
    check("copi_stable", fr_viol, 0);
    check("stray_sclk", stray, 0);
  endtask

  // Pulse start (optionally extra ignored pulses at fixed offsets), then verify the frame end to end.
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] dt, input bit extra);
    int d, k, d0, f0;
    logic [15:0] exp;
    d = cur_div();
    wait_idle();
    d0 = dones; f0 = frames;
    exp = {w, a, dt};
    start = 1'b1; wr = w; addr = a; wdata = dt;
    k = 0;
    while (k < 40 * d + 20) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      wr = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
      if (extra && (k == 10 || k == 60)) start = 1'b1;
      if (k == 1) check("busy_after_accept", int'(m_busy), 1);
      if (m_done === 1'b1) break;
    end
    start = 1'b0;
    check("done_latency", k, 1 + 33 * d);
    @(negedge clk);
    check("done_one_cycle", int'(m_done), 0);
    check_frame(exp, d);
    if (w) exp_regs[a] = dt;
    check("periph_reg", int'(periph[a]), int'(exp_regs[a]));
    if (extra) repeat (2 * d + 20) @(negedge clk);
    check("frames_per_send", frames - f0, 1);
    check("dones_per_send", dones - d0, 1);
  endtask

  initial begin
    int n, d0, a0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ncs", int'(ncs_a), 1);
    check("rst_sclk", int'(sclk_a), 0);
    check("rst_copi", int'(copi_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_ncs_b", int'(ncs_b), 1);
    repeat (3) @(negedge clk);

    send(1'b1, 7'h04, 8'hA5, 1'b0);
    send(1'b0, 7'h00, 8'hFF, 1'b0);

    for (int i = 0; i < 5; i++) begin
      send(1'b1, 7'(i), 8'(8'h11 * (i + 1)), 1'b0);
      check("ncs_high_gap", int'(last_high >= 8), 1);
    end
    for (int i = 0; i < 5; i++) check("loopback_reg", int'(periph[i]), int'(8'(8'h11 * (i + 1))));

    // Start held high: the second accept must wait for IDLE, giving the minimum spacing.
    wait_idle();
    a0 = acc_cnt;
    start = 1'b1; wr = 1'b1; addr = 7'h10; wdata = 8'h5A;
    n = 0;
    while (acc_cnt < a0 + 2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    @(negedge clk);
    check("accept_spacing", acc_last - acc_prev, 1 + 35 * DA);
    check("min_ncs_high", last_high, 1 + 2 * DA);
    wait_idle();
    exp_regs[7'h10] = 8'h5A;
    check("held_start_reg", int'(periph[7'h10]), 8'h5A);

    send(1'b1, 7'h22, 8'hC7, 1'b1);

    for (int i = 0; i < 10; i++)
      send(1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 1'b0);

    // Abort mid-frame after the 7th rising edge.
    wait_idle();
    d0 = dones;
    start = 1'b1; wr = 1'b1; addr = 7'h01; wdata = 8'hC3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (edges < 7 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ncs", int'(ncs_a), 1);
    check("abort_sclk", int'(sclk_a), 0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_done", int'(done_a), 0);
    @(negedge clk);
    check("abort_edges", fr_edges, 7);
    check("abort_no_done", dones - d0, 0);
    check("abort_no_write", int'(periph[1]), int'(exp_regs[1]));
    send(1'b1, 7'h01, 8'h3C, 1'b0);

    sel = 1'b1;
    repeat (2) @(negedge clk);
    send(1'b1, 7'h02, 8'h80, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter: CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 4..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to send a frame; honoured only when busy=0.
REQ-005 wr  input  1  frame bit 15 (1 = write, 0 = read/no-op at the peripheral).
REQ-006 addr  input  7  register address, frame bits 14:8.
REQ-007 wdata  input  8  register data, frame bits 7:0.
REQ-008 sclk  output  1  SPI clock, mode 0, idle low.
REQ-009 copi  output  1  serial data to peripheral, MSB first.
REQ-010 ncs  output  1  chip select, active-low, idle high.
REQ-011 busy  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-012 done  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 All outputs shall be registered; no combinational path from inputs to outputs.
REQ-014 The FSM shall have states IDLE, LEAD, SHIFT_HI, SHIFT_LO, GAP.
REQ-015 IDLE: ncs=1, sclk=0, copi=0, busy=0; start=1 latches {wr,addr,wdata} into a 16-bit shift register, loads bit counter to 15, moves to LEAD.
REQ-016 Inputs wr/addr/wdata shall be sampled only on the accept cycle; later changes shall not affect the frame in flight.
REQ-017 LEAD: ncs=0, sclk=0, copi=frame[15], held CLK_DIV cycles, then SHIFT_HI.
REQ-018 SHIFT_HI: sclk=1 for CLK_DIV cycles, copi stable, then SHIFT_LO.
REQ-019 SHIFT_LO: sclk=0 for CLK_DIV cycles; on entry copi shall advance to the next lower frame bit unless the bit counter is 0.
REQ-020 SHIFT_LO exit: bit counter>0 -> decrement, SHIFT_HI; bit counter=0 -> GAP.
REQ-021 Exactly 16 SCLK rising edges shall occur per frame; copi shall never change within CLK_DIV cycles before or after a rising edge.
REQ-022 ncs low duration shall be exactly 33*CLK_DIV clk cycles (LEAD + 16 full SCLK periods).
REQ-023 GAP entry cycle: ncs=1, copi=0, done=1 for exactly that cycle; GAP shall last 2*CLK_DIV cycles with busy=1, then IDLE.
REQ-024 start while busy=1 shall be ignored, not queued.
REQ-025 start asserted on the same cycle GAP returns to IDLE shall be ignored; start is accepted only while in IDLE.
REQ-026 Accept-to-done latency shall be 1+33*CLK_DIV cycles; accept-to-next-accept minimum 1+35*CLK_DIV cycles.
REQ-027 Half-period counter shall be sized for CLK_DIV=255 and shall not wrap within a state.

Reset
REQ-028 rst=1 at a rising clk edge shall force IDLE with ncs=1, sclk=0, copi=0, busy=0, done=0 on that edge, regardless of state.
REQ-029 Reset mid-frame shall abort without a done pulse; the ncs rise discards the partial frame at the peripheral.
REQ-030 rst has priority over start on the same cycle.

Verification
REQ-031 CLK_DIV=4, start with wr=1, addr=0x04, wdata=0xA5 -> copi bits 1000_0100_1010_0101 at 16 sclk rising edges; done pulse 133 cycles after accept; spi_peripheral loopback pwm_duty_cycle=0xA5.
REQ-032 Loopback, five back-to-back frames to addr 0..4 with data 0x11,0x22,0x33,0x44,0x55 -> all five spi_peripheral registers hold those values; ncs high >=8 cycles between frames.
REQ-033 wr=0, addr=0x00, wdata=0xFF -> correct waveform, done pulses, spi_peripheral en_reg_out_7_0 unchanged.
REQ-034 start pulsed at 10 and 60 cycles after an accepted start -> ignored; exactly one frame, one done pulse.
REQ-035 rst asserted after 7th sclk rising edge -> next edge ncs=1, sclk=0, busy=0, no done; next frame addr=0x01, wdata=0x3C delivered intact.
REQ-036 CLK_DIV=255, addr=0x02, wdata=0x80 -> sclk half-period 255 cycles, ncs low 8415 cycles, frame delivered.
